// File: rtl/qbus_arbiter.sv
// Bus-ownership arbiter (CPU vs DMA via DMR/DMGO/SACK) for the 1801VM1 bus.
// Define QBUS_TIMEOUT_EN to compile in the CPU reply watchdog and berror.
module qbus_arbiter #(
    parameter int unsigned BUS_TIMEOUT   = 63,
    parameter int unsigned GRANT_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       ce,
    input  logic       cpu_req,
    input  logic       rply,
    input  logic       dmr,
    input  logic       sack,
    output logic       dmgo,
    output logic       cpu_hold,
    output logic       dma_active,
    output logic       berror,
    output logic [1:0] owner
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CPU   = 2'd1,
        S_GRANT = 2'd2,
        S_DMA   = 2'd3
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] gcnt_q, gcnt_d;
    logic       turn_q, turn_d;
    logic       cpu_ok;

`ifdef QBUS_TIMEOUT_EN
    logic [5:0] bcnt_q, bcnt_d;
    logic       berr_q, berr_d;
    logic       wait_q, wait_d;

    // After a timeout the stuck request must drop before a new CPU cycle
    assign cpu_ok = cpu_req && !wait_q;
`else
    logic unused_rply;

    assign unused_rply = rply;
    assign cpu_ok      = cpu_req;
`endif

    always_comb begin
        state_d = state_q;
        gcnt_d  = gcnt_q;
        turn_d  = turn_q;
`ifdef QBUS_TIMEOUT_EN
        bcnt_d  = bcnt_q;
        berr_d  = berr_q;
        wait_d  = wait_q;
`endif
        if (ce) begin
`ifdef QBUS_TIMEOUT_EN
            berr_d = 1'b0;
            if (!cpu_req) wait_d = 1'b0;
`endif
            unique case (state_q)
                S_IDLE: begin
                    // A CPU that has stopped asking forfeits its turn
                    if (!cpu_req) turn_d = 1'b0;
                    if (cpu_ok) state_d = S_CPU;
                    else if (dmr && !turn_q) state_d = S_GRANT;
                end
                S_CPU: begin
                    if (!cpu_req) begin
                        turn_d  = 1'b0;
                        state_d = (dmr && !turn_q) ? S_GRANT : S_IDLE;
                    end
`ifdef QBUS_TIMEOUT_EN
                    else if (rply) begin
                        bcnt_d = '0;
                    end else if (bcnt_q == 6'(BUS_TIMEOUT - 1)) begin
                        state_d = S_IDLE;
                        berr_d  = 1'b1;
                        wait_d  = 1'b1;
                        turn_d  = 1'b0;
                    end else begin
                        bcnt_d = bcnt_q + 6'd1;
                    end
`endif
                end
                S_GRANT: begin
                    if (sack) state_d = S_DMA;
                    else if (!dmr) state_d = S_IDLE;
                    else if (gcnt_q == 4'(GRANT_TIMEOUT - 1)) state_d = S_IDLE;
                    else gcnt_d = gcnt_q + 4'd1;
                end
                S_DMA: begin
                    if (!sack) begin
                        state_d = S_IDLE;
                        if (cpu_req) turn_d = 1'b1;
                    end
                end
            endcase
            if (state_d != state_q) begin
                gcnt_d = '0;
`ifdef QBUS_TIMEOUT_EN
                bcnt_d = '0;
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            gcnt_q  <= '0;
            turn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            gcnt_q  <= gcnt_d;
            turn_q  <= turn_d;
        end
    end

`ifdef QBUS_TIMEOUT_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            bcnt_q <= '0;
            berr_q <= 1'b0;
            wait_q <= 1'b0;
        end else begin
            bcnt_q <= bcnt_d;
            berr_q <= berr_d;
            wait_q <= wait_d;
        end
    end

    assign berror = berr_q;
`else
    assign berror = 1'b0;
`endif

    assign owner      = state_q;
    assign dmgo       = (state_q == S_GRANT);
    assign cpu_hold   = (state_q == S_GRANT) || (state_q == S_DMA);
    assign dma_active = (state_q == S_DMA);

endmodule

// File: tb/tb_qbus_arbiter.sv
// Scoreboard bench for qbus_arbiter: directed ticks push expected state,
// a monitor pops and compares one record after every clock edge.
module tb_qbus_arbiter;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       ce = 1'b0;
    logic       cpu_req = 1'b0;
    logic       rply = 1'b0;
    logic       dmr = 1'b0;
    logic       sack = 1'b0;
    logic       dmgo, cpu_hold, dma_active, berror;
    logic [1:0] owner;

    int errors = 0;
    int checks = 0;

    typedef struct {
        string      name;
        logic [1:0] owner;
        logic       berr;
    } exp_t;

    exp_t sb[$];

`ifdef QBUS_TIMEOUT_EN
    localparam bit WD = 1'b1;
`else
    localparam bit WD = 1'b0;
`endif

    qbus_arbiter dut (
        .clk(clk),
        .reset_n(reset_n),
        .ce(ce),
        .cpu_req(cpu_req),
        .rply(rply),
        .dmr(dmr),
        .sack(sack),
        .dmgo(dmgo),
        .cpu_hold(cpu_hold),
        .dma_active(dma_active),
        .berror(berror),
        .owner(owner)
    );

    always #5 clk = ~clk;

    // Expected flags follow from the owner code alone
    task automatic compare(input exp_t e);
        logic xg, xh, xa;
        xg = (e.owner == 2'd2);
        xh = (e.owner >= 2'd2);
        xa = (e.owner == 2'd3);
        checks++;
        if (owner !== e.owner || dmgo !== xg || cpu_hold !== xh ||
            dma_active !== xa || berror !== e.berr) begin
            errors++;
            $display("FAIL %s: got owner=%0d dmgo=%b hold=%b dma=%b berr=%b want owner=%0d dmgo=%b hold=%b dma=%b berr=%b",
                     e.name, owner, dmgo, cpu_hold, dma_active, berror,
                     e.owner, xg, xh, xa, e.berr);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                compare(e);
            end
        end
    end

    task automatic tick(input logic c, input logic cr, input logic rp,
                        input logic dr, input logic sk, input string nm,
                        input logic [1:0] ow, input logic be);
        exp_t e;
        @(negedge clk);
        ce      = c;
        cpu_req = cr;
        rply    = rp;
        dmr     = dr;
        sack    = sk;
        e.name  = nm;
        e.owner = ow;
        e.berr  = be;
        sb.push_back(e);
        @(posedge clk);
    endtask

    task automatic direct(input string nm);
        exp_t e;
        e.name  = nm;
        e.owner = 2'd0;
        e.berr  = 1'b0;
        compare(e);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        direct("reset_state");
        @(negedge clk);
        reset_n = 1'b1;

        // Simple DMA
        tick(1, 0, 0, 1, 0, "dmr_dmgo", 2'd2, 0);
        tick(1, 0, 0, 1, 1, "sack_dma", 2'd3, 0);
        tick(1, 0, 0, 0, 1, "dma_hold", 2'd3, 0);
        tick(1, 0, 0, 0, 0, "sack_fall", 2'd0, 0);

        // ce freeze and request withdrawal
        tick(0, 0, 0, 1, 0, "ce_freeze_idle", 2'd0, 0);
        tick(1, 0, 0, 1, 0, "grant_again", 2'd2, 0);
        tick(0, 0, 0, 1, 1, "ce_freeze_grant", 2'd2, 0);
        tick(1, 0, 0, 0, 0, "dmr_withdraw", 2'd0, 0);

        // Collision: CPU wins, then DMA gets the bus
        tick(1, 1, 0, 1, 0, "collide", 2'd1, 0);
        tick(1, 1, 1, 1, 0, "cpu_rply", 2'd1, 0);
        tick(1, 0, 0, 1, 0, "cpu_to_grant", 2'd2, 0);
        tick(1, 0, 0, 1, 1, "grant_to_dma", 2'd3, 0);

        // Fairness: one CPU cycle between DMA tenures
        tick(1, 1, 0, 1, 0, "dma_end_turn", 2'd0, 0);
        tick(1, 1, 0, 1, 0, "fair_cpu", 2'd1, 0);
        tick(1, 1, 1, 1, 0, "fair_cpu_rply", 2'd1, 0);
        tick(1, 0, 0, 1, 0, "turn_to_idle", 2'd0, 0);
        tick(1, 0, 0, 1, 0, "fair_grant", 2'd2, 0);
        tick(1, 0, 0, 0, 0, "fair_release", 2'd0, 0);

        // sack without grant is ignored
        tick(1, 0, 0, 0, 1, "stray_sack", 2'd0, 0);

        // Grant timeout on the 15th tick in GRANT
        tick(1, 0, 0, 1, 0, "gto_enter", 2'd2, 0);
        for (int k = 1; k < 15; k++)
            tick(1, 0, 0, 1, 0, "gto_wait", 2'd2, 0);
        tick(1, 0, 0, 1, 0, "gto_fire", 2'd0, 0);
        tick(1, 0, 0, 0, 0, "gto_idle", 2'd0, 0);

        // Reply watchdog
        tick(1, 1, 0, 0, 0, "wd_enter", 2'd1, 0);
        for (int k = 1; k < 63; k++)
            tick(1, 1, 0, 0, 0, "wd_wait", 2'd1, 0);
        tick(1, 1, 0, 0, 0, "wd_fire", WD ? 2'd0 : 2'd1, WD);
        tick(1, 1, 0, 0, 0, "wd_after", WD ? 2'd0 : 2'd1, 0);
        tick(1, 0, 0, 0, 0, "wd_req_fall", 2'd0, 0);
        tick(1, 1, 0, 0, 0, "wd_new_cpu", 2'd1, 0);
        tick(1, 1, 1, 0, 0, "wd_new_rply", 2'd1, 0);
        tick(1, 0, 0, 0, 0, "wd_new_done", 2'd0, 0);

        // Async reset in the middle of a grant
        tick(1, 0, 0, 1, 0, "pre_reset_grant", 2'd2, 0);
        @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        direct("async_reset");
        @(posedge clk);
        #2;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
